// File: rtl/clk_period_meter_if.sv
// Signal bundle between a monitored divided clock and its period meter.
// The master drives sig_in; the slave (the meter) returns the measurements.
interface clk_period_meter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             sig_in;
    logic             tick;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             stalled;

    modport master (
        output sig_in,
        input  tick,
        input  period,
        input  high_time,
        input  valid,
        input  stalled
    );

    modport slave (
        input  sig_in,
        output tick,
        output period,
        output high_time,
        output valid,
        output stalled
    );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous divided clock in clk_in cycles,
// emits a tick per rising edge and flags a source that stops toggling.
module clk_period_meter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 32'd100_000_000
) (
    input  logic                clk_in,
    input  logic                rst,
    clk_period_meter_if.slave   bus
);
    localparam logic [WIDTH-1:0] TimeoutW = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CntMax   = '1;
    localparam logic [WIDTH-1:0] CntOne   = WIDTH'(1);

    typedef enum logic {StIdle, StMeasure} state_e;

    state_e           r_state;
    logic             r_s1, r_s2, r_s3;
    logic [WIDTH-1:0] r_cnt, r_hcnt;
    logic [WIDTH-1:0] r_period, r_high_time;
    logic             r_tick, r_valid, r_stalled;
    logic             w_rise;
    logic             w_timeout;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TimeoutW);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_tick      <= 1'b0;
            r_valid     <= 1'b0;
            r_stalled   <= 1'b0;
        end else begin
            r_s1    <= bus.sig_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_tick  <= w_rise;
            r_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_rise) begin
                        r_cnt     <= CntOne;
                        r_hcnt    <= CntOne;
                        r_stalled <= 1'b0;
                        r_state   <= StMeasure;
                    end
                end
                StMeasure: begin
                    // A rise in the timeout cycle is a normal measurement, not a stall.
                    if (w_rise) begin
                        r_period    <= r_cnt;
                        r_high_time <= r_hcnt;
                        r_cnt       <= CntOne;
                        r_hcnt      <= CntOne;
                        r_valid     <= 1'b1;
                    end else if (w_timeout) begin
                        r_stalled <= 1'b1;
                        r_cnt     <= '0;
                        r_hcnt    <= '0;
                        r_state   <= StIdle;
                    end else begin
                        if (r_cnt != CntMax) r_cnt <= r_cnt + CntOne;
                        if (r_s2 && (r_hcnt != CntMax)) r_hcnt <= r_hcnt + CntOne;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.tick      = r_tick;
    assign bus.period    = r_period;
    assign bus.high_time = r_high_time;
    assign bus.valid     = r_valid;
    assign bus.stalled   = r_stalled;
endmodule
